// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared definitions for the barrel-shift arbiter: FSM state encoding and
// default geometry of the shared rotator.
package barrel_shift_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;
  localparam int DEF_SW   = 3;
  localparam int DEF_IDW  = 2;

endpackage : barrel_shift_arbiter_pkg

// File: rtl/barrel_shift_arbiter_if.sv
// Request/response bus between the shift clients and the arbiter.
// master = client side (issues requests, consumes results),
// slave  = arbiter side.
interface barrel_shift_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int SW   = 3,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*SW-1:0] req_shamt;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [DW-1:0]      resp_data;
  logic [IDW-1:0]     resp_id;
  logic               resp_ready;

  modport master (
    output req_valid, req_data, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface : barrel_shift_arbiter_if

// File: rtl/barrel_shift_arbiter_rotl.sv
// Combinational rotate-left core built from SW log stages; stage k rotates
// by 2**k when shamt bit k is set. Rotation is modulo DW since shamt < DW.
module barrel_rotl_core #(
  parameter int DW = 8,
  parameter int SW = 3
) (
  input  logic [DW-1:0] data_i,
  input  logic [SW-1:0] shamt_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] stage_s [0:SW];

  assign stage_s[0] = data_i;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int AMT = 1 << k;
    assign stage_s[k+1] = shamt_i[k]
                        ? ((stage_s[k] << AMT) | (stage_s[k] >> (DW - AMT)))
                        : stage_s[k];
  end

  assign data_o = stage_s[SW];

endmodule : barrel_rotl_core

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter in front of one shared rotate-left core. A granted
// request is captured, rotated in the SHIFT cycle and held in RESP until
// the consumer accepts it; one transaction is in flight at a time.
module barrel_shift_arbiter
  import barrel_shift_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int SW   = DEF_SW,
  parameter int IDW  = DEF_IDW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  barrel_shift_arbiter_if.slave   bus,
  output logic                    busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]  op_data_q, op_data_d;
  logic [SW-1:0]  op_shamt_q, op_shamt_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           resp_valid_q, resp_valid_d;
  logic [DW-1:0]  resp_data_q, resp_data_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;

  logic            grant_valid_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic [DW-1:0]   rot_result_s;

  barrel_rotl_core #(
    .DW (DW),
    .SW (SW)
  ) u_rotl (
    .data_i  (op_data_q),
    .shamt_i (op_shamt_q),
    .data_o  (rot_result_s)
  );

  // Pick the first valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    idx           = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_valid_s && bus.req_valid[idx]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = IDW'(idx);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // FSM next state, one-hot grant and register next values (default: hold).
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_data_d    = op_data_q;
    op_shamt_d   = op_shamt_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    req_ready_s  = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          // Grant is only offered to a valid port, so the grant is the handshake.
          req_ready_s[grant_idx_s] = 1'b1;
          op_data_d  = bus.req_data[int'(grant_idx_s)*DW +: DW];
          op_shamt_d = bus.req_shamt[int'(grant_idx_s)*SW +: SW];
          op_id_d    = grant_idx_s;
          rr_ptr_d   = IDW'((int'(grant_idx_s) + 1) % NREQ);
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        resp_data_d  = rot_result_s;
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      op_data_q    <= '0;
      op_shamt_q   <= '0;
      op_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_data_q    <= op_data_d;
      op_shamt_q   <= op_shamt_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // The FSM sits in IDLE while reset is held; mask the grant so no
  // requester sees an accept during reset.
  assign bus.req_ready  = rst_n ? req_ready_s : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = (state_q != ST_IDLE);

endmodule : barrel_shift_arbiter

// File: tb/tb_barrel_shift_arbiter.sv
// Directed self-checking bench for barrel_shift_arbiter (NREQ=4, DW=8).
module tb_barrel_shift_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_fail;

  barrel_shift_arbiter_if #(.NREQ(4), .DW(8), .SW(3), .IDW(2)) bus ();

  barrel_shift_arbiter #(.NREQ(4), .DW(8), .SW(3), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic v, input logic [7:0] d, input logic [2:0] s);
    bus.req_valid[i]       = v;
    bus.req_data[i*8 +: 8]  = d;
    bus.req_shamt[i*3 +: 3] = s;
  endtask

  logic [7:0] rot_data [4];
  logic [2:0] rot_shamt[4];
  logic [7:0] rot_exp  [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    bus.req_valid  = 4'b1111;
    bus.req_data   = 32'h0;
    bus.req_shamt  = 12'h0;
    bus.resp_ready = 1'b0;
    rot_data  = '{8'h2B, 8'hF6, 8'hB1, 8'h01};
    rot_shamt = '{3'd4, 3'd5, 3'd3, 3'd0};
    rot_exp   = '{8'hB2, 8'hDE, 8'h8D, 8'h01};

    // Reset with every requester valid
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check_val("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_resp_data", 32'(bus.resp_data), 32'h0);
    check_val("rst_resp_id", 32'(bus.resp_id), 32'h0);
    bus.req_valid = 4'b0000;
    rst_n = 1'b1;

    // Single request on port 0: B1 rotl 3 = 8D, valid two cycles after handshake
    set_port(0, 1'b1, 8'hB1, 3'd3);
    #1;
    check_val("single_grant", 32'(bus.req_ready), 32'h1);
    check_val("single_idle_busy", 32'(busy), 32'h0);
    step();
    set_port(0, 1'b0, 8'h00, 3'd0);
    #1;
    check_val("single_shift_busy", 32'(busy), 32'h1);
    check_val("single_shift_valid", 32'(bus.resp_valid), 32'h0);
    check_val("single_shift_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_val("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    check_val("single_resp_data", 32'(bus.resp_data), 32'h8D);
    check_val("single_resp_id", 32'(bus.resp_id), 32'h0);
    bus.resp_ready = 1'b1;
    step();
    check_val("single_done_valid", 32'(bus.resp_valid), 32'h0);
    check_val("single_done_busy", 32'(busy), 32'h0);

    // Reset pulse to bring rr_ptr back to 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;

    // Strict rotation with all four ports requesting, resp_ready held high
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, rot_data[p], rot_shamt[p]);
    for (int j = 0; j < 5; j++) begin
      int id;
      id = j % 4;
      #1;
      check_val($sformatf("rot%0d_grant", j), 32'(bus.req_ready), 32'(1 << id));
      step();
      step();
      check_val($sformatf("rot%0d_valid", j), 32'(bus.resp_valid), 32'h1);
      check_val($sformatf("rot%0d_data", j), 32'(bus.resp_data), 32'(rot_exp[id]));
      check_val($sformatf("rot%0d_id", j), 32'(bus.resp_id), 32'(id));
      step();
    end

    // Back-pressure on port 1 (rr_ptr is now 1): F6 rotl 5 = DE
    for (int p = 0; p < 4; p++) set_port(p, 1'b0, 8'h00, 3'd0);
    set_port(1, 1'b1, 8'hF6, 3'd5);
    bus.resp_ready = 1'b0;
    #1;
    check_val("bp_grant", 32'(bus.req_ready), 32'h2);
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      check_val($sformatf("bp%0d_valid", c), 32'(bus.resp_valid), 32'h1);
      check_val($sformatf("bp%0d_data", c), 32'(bus.resp_data), 32'hDE);
      check_val($sformatf("bp%0d_id", c), 32'(bus.resp_id), 32'h1);
      check_val($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'h0);
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    check_val("bp_release_busy", 32'(busy), 32'h0);
    check_val("bp_release_valid", 32'(bus.resp_valid), 32'h0);
    check_val("bp_release_regrant", 32'(bus.req_ready), 32'h2);
    set_port(1, 1'b0, 8'h00, 3'd0);

    // Serve port 2 (rr_ptr 2 -> 3): 2B rotl 4 = B2
    set_port(2, 1'b1, 8'h2B, 3'd4);
    #1;
    check_val("wrap_pre_grant", 32'(bus.req_ready), 32'h4);
    step();
    set_port(2, 1'b0, 8'h00, 3'd0);
    step();
    check_val("wrap_pre_data", 32'(bus.resp_data), 32'hB2);
    check_val("wrap_pre_id", 32'(bus.resp_id), 32'h2);
    step();

    // Wrap: rr_ptr=3, only port 1 valid -> port 1 granted
    set_port(1, 1'b1, 8'hB1, 3'd3);
    #1;
    check_val("wrap_grant", 32'(bus.req_ready), 32'h2);
    step();
    set_port(1, 1'b0, 8'h00, 3'd0);
    step();
    check_val("wrap_data", 32'(bus.resp_data), 32'h8D);
    check_val("wrap_id", 32'(bus.resp_id), 32'h1);
    step();

    // rr_ptr should now be 2: ports 1,2,3 valid -> port 2 wins
    set_port(1, 1'b1, 8'h11, 3'd1);
    set_port(2, 1'b1, 8'h22, 3'd2);
    set_port(3, 1'b1, 8'h33, 3'd3);
    #1;
    check_val("wrap_ptr_grant", 32'(bus.req_ready), 32'h4);
    step();
    for (int p = 0; p < 4; p++) set_port(p, 1'b0, 8'h00, 3'd0);
    #1;
    check_val("midrst_shift_busy", 32'(busy), 32'h1);

    // Asynchronous reset while in SHIFT
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'h0);
    check_val("midrst_valid", 32'(bus.resp_valid), 32'h0);
    check_val("midrst_data", 32'(bus.resp_data), 32'h0);
    check_val("midrst_id", 32'(bus.resp_id), 32'h0);
    step();
    check_val("midrst_held_valid", 32'(bus.resp_valid), 32'h0);
    set_port(2, 1'b1, 8'h22, 3'd2);
    set_port(3, 1'b1, 8'h33, 3'd3);
    #1;
    check_val("midrst_held_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    check_val("midrst_first_grant", 32'(bus.req_ready), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_barrel_shift_arbiter
